// File: rtl/sensor_alarm_display_if.sv
// Sensor/display pin bundle for sensor_alarm_display.
// The master side drives the raw sensor levels and the acknowledge pulse.
// The slave side, which is the alarm display, drives the segment, digit-enable
// and alarm status outputs.
interface sensor_alarm_display_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] sensor_in;  // raw asynchronous sensor levels, 1 = fire
    logic              ack;        // one-cycle acknowledge pulse
    logic [6:0]        seg;        // active-low segments, seg[0]=a .. seg[6]=g
    logic [3:0]        an;         // active-low digit enables, an[3] = leftmost
    logic              alarm;      // any channel latched
    logic [3:0]        alarm_ch;   // channel currently displayed, 0 in SAFE

    modport master (
        output sensor_in, ack,
        input  seg, an, alarm, alarm_ch
    );

    modport slave (
        input  sensor_in, ack,
        output seg, an, alarm, alarm_ch
    );
endinterface

// File: rtl/sensor_alarm_display.sv
// Multi-channel fire alarm with a 4-digit multiplexed seven-segment display.
// Each sensor input is synchronised, debounced and latched until it is
// acknowledged. The display shows "SAFE" when no channel is latched. Otherwise
// it shows "FIr<n>" and rotates through the latched channels.
// Optional feature: define ALARM_BLINK_EN to blink the display while in FIRE.
// The blink period is set by BLINK_CYC.
module sensor_alarm_display #(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int SCAN_DIV     = 100000,
    parameter int ROT_CYC      = 50000000
`ifdef ALARM_BLINK_EN
    ,
    parameter int BLINK_CYC    = 25000000
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    sensor_alarm_display_if.slave bus
);

    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ROT_W  = (ROT_CYC > 1) ? $clog2(ROT_CYC) : 1;

    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ROT_W-1:0]  ROT_MAX  = ROT_W'(ROT_CYC - 1);

    localparam logic [6:0] GLYPH_S = 7'h12;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_F = 7'h0E;
    localparam logic [6:0] GLYPH_E = 7'h06;
    localparam logic [6:0] GLYPH_I = 7'h79;
    localparam logic [6:0] GLYPH_R = 7'h2F;

    typedef enum logic {
        ST_SAFE = 1'b0,
        ST_FIRE = 1'b1
    } state_e;

    // Active-low decimal digit glyphs.
    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] deb_q, deb_d, deb_prev_q;
    logic [DEB_W-1:0]  deb_cnt_q [NUM_CH];
    logic [DEB_W-1:0]  deb_cnt_d [NUM_CH];
    logic [NUM_CH-1:0] latch_q, latch_d;
    logic              alarm_q;

    state_e            state_q, state_d;
    logic [3:0]        cur_ch_q, cur_ch_d;
    logic [ROT_W-1:0]  rot_cnt_q, rot_cnt_d;
    logic [3:0]        lowest_ch, next_ch;
    logic              cur_latched;
    int                nxt_dist, nxt_best;

    logic [SCAN_W-1:0] div_q;
    logic [1:0]        scan_idx_q;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    // Two-flop synchroniser on every raw sensor input.
    // NOTE: sequential state uses non-blocking assignments so that all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sensor_in;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive cycles where the synced level differs from the accepted level.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no latches are inferred.
        deb_d = deb_q;
        for (int i = 0; i < NUM_CH; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (deb_cnt_q[i] == DEB_MAX) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers, plus the delayed level used for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            // NOTE: the counter array is a bank of flops, not a RAM, so it can and must be reset.
            for (int i = 0; i < NUM_CH; i++) deb_cnt_q[i] <= '0;
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < NUM_CH; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    // Alarm latches: a debounced rising edge sets the latch and wins over ack.
    // ack clears a latch only when its debounced level is 0.
    always_comb begin
        latch_d = (latch_q & ~({NUM_CH{bus.ack}} & ~deb_q)) | (deb_q & ~deb_prev_q);
    end

    // Latch bank and the registered any-alarm flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            alarm_q <= |latch_q;
        end
    end

    // Find the lowest latched channel, the next latched channel above cur_ch
    // (wrapping), and whether cur_ch itself is still latched.
    always_comb begin
        lowest_ch   = '0;
        next_ch     = cur_ch_q;
        cur_latched = 1'b0;
        nxt_dist    = 0;
        nxt_best    = NUM_CH + 1;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (latch_q[j]) lowest_ch = 4'(j);
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (cur_ch_q == 4'(j)) cur_latched = latch_q[j];
            nxt_dist = j - int'(cur_ch_q);
            if (nxt_dist <= 0) nxt_dist = nxt_dist + NUM_CH;
            if (latch_q[j] && (nxt_dist < nxt_best)) begin
                nxt_best = nxt_dist;
                next_ch  = 4'(j);
            end
        end
    end

    // SAFE/FIRE next-state logic with channel rotation.
    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        rot_cnt_d = rot_cnt_q;
        case (state_q)
            ST_SAFE: begin
                if (|latch_q) begin
                    state_d   = ST_FIRE;
                    cur_ch_d  = lowest_ch;
                    rot_cnt_d = '0;
                end
            end
            ST_FIRE: begin
                if (!(|latch_q)) begin
                    state_d   = ST_SAFE;
                    cur_ch_d  = '0;
                    rot_cnt_d = '0;
                end else if (!cur_latched) begin
                    cur_ch_d  = next_ch;
                    rot_cnt_d = '0;
                end else if (rot_cnt_q == ROT_MAX) begin
                    cur_ch_d  = next_ch;
                    rot_cnt_d = '0;
                end else begin
                    rot_cnt_d = rot_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_SAFE;
                cur_ch_d  = '0;
                rot_cnt_d = '0;
            end
        endcase
    end

    // FSM state, displayed channel and rotation counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SAFE;
            cur_ch_q  <= '0;
            rot_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            rot_cnt_q <= rot_cnt_d;
        end
    end

    // Free-running digit scan: the index steps 3,2,1,0 once every SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            scan_idx_q <= 2'd3;
        end else if (div_q == SCAN_MAX) begin
            div_q      <= '0;
            scan_idx_q <= scan_idx_q - 2'd1;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

`ifdef ALARM_BLINK_EN
    localparam int BLINK_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYC - 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_phase_q;

    // Blink timer runs only in FIRE. It is held clear otherwise, so every FIRE
    // entry starts with the display on.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (state_q != ST_FIRE) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= ~blink_phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end
`endif

    // Glyph and digit-enable selection from the scan index and the FSM state.
    always_comb begin
        an_d             = 4'hF;
        an_d[scan_idx_q] = 1'b0;
        seg_d            = 7'h7F;
        if (state_q == ST_FIRE) begin
            case (scan_idx_q)
                2'd3:    seg_d = GLYPH_F;
                2'd2:    seg_d = GLYPH_I;
                2'd1:    seg_d = GLYPH_R;
                default: seg_d = digit_glyph(cur_ch_q);
            endcase
        end else begin
            case (scan_idx_q)
                2'd3:    seg_d = GLYPH_S;
                2'd2:    seg_d = GLYPH_A;
                2'd1:    seg_d = GLYPH_F;
                default: seg_d = GLYPH_E;
            endcase
        end
`ifdef ALARM_BLINK_EN
        if ((state_q == ST_FIRE) && blink_phase_q) an_d = 4'hF;
`endif
    end

    // Registered display outputs; reset blanks the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'h7F;
            an_q  <= 4'hF;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.alarm    = alarm_q;
    assign bus.alarm_ch = cur_ch_q;

endmodule

// File: tb/tb_sensor_alarm_display.sv
// Self-checking bench for sensor_alarm_display.
// A behavioural model built from the alarm rules checks all outputs at every
// falling clock edge. Directed steps pin latency, rotation and acknowledge
// behaviour with literal values.
module tb_sensor_alarm_display;

    localparam int NUM_CH = 4;
    localparam int DEB    = 4;
    localparam int SDIV   = 2;
    localparam int ROT    = 16;
    localparam int BLINK  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sensor_alarm_display_if #(.NUM_CH(NUM_CH)) bus ();

    sensor_alarm_display #(
        .NUM_CH      (NUM_CH),
        .DEBOUNCE_CYC(DEB),
        .SCAN_DIV    (SDIV),
        .ROT_CYC     (ROT)
`ifdef ALARM_BLINK_EN
        ,
        .BLINK_CYC   (BLINK)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] safe_g [4] = '{7'h06, 7'h0E, 7'h08, 7'h12};  // digit 0..3 = E,F,A,S
    logic [6:0] fire_g [4] = '{7'h7F, 7'h2F, 7'h79, 7'h0E};  // digit 1..3 = r,I,F
    logic [6:0] dig_g [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [NUM_CH-1:0] hist [$];  // raw samples, front = most recent edge
    logic [NUM_CH-1:0] m_deb, m_deb_old, m_latch;
    bit                m_alarm, m_fire;
    int                m_cur, m_dwell, m_cyc, m_age;
    logic [6:0]        m_seg;
    logic [3:0]        m_an;

    function automatic int lowest(input logic [NUM_CH-1:0] l);
        for (int c = 0; c < NUM_CH; c++) if (l[c]) return c;
        return 0;
    endfunction

    function automatic int next_after(input logic [NUM_CH-1:0] l, input int cur);
        for (int off = 1; off <= NUM_CH; off++)
            if (l[(cur + off) % NUM_CH]) return (cur + off) % NUM_CH;
        return cur;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k <= DEB; k++) hist.push_back('0);
        m_deb = '0; m_deb_old = '0; m_latch = '0;
        m_alarm = 0; m_fire = 0;
        m_cur = 0; m_dwell = 0; m_cyc = 0; m_age = 0;
        m_seg = 7'h7F; m_an = 4'hF;
    endtask

    task automatic model_step();
        logic [NUM_CH-1:0] deb_new, latch_new;
        bit                fire_new, flip;
        int                cur_new, dwell_new, age_new, idx;
        // Accepted level flips once the last DEB synchronised samples all disagree with it.
        for (int c = 0; c < NUM_CH; c++) begin
            flip = 1;
            for (int k = 1; k <= DEB; k++) if (hist[k][c] == m_deb[c]) flip = 0;
            deb_new[c] = flip ? ~m_deb[c] : m_deb[c];
        end
        latch_new = (m_latch & ~(bus.ack ? ~m_deb : '0)) | (m_deb & ~m_deb_old);
        fire_new = m_fire; cur_new = m_cur; dwell_new = m_dwell;
        if (!m_fire) begin
            if (m_latch != 0) begin
                fire_new = 1; cur_new = lowest(m_latch); dwell_new = 0;
            end
        end else if (m_latch == 0) begin
            fire_new = 0; cur_new = 0; dwell_new = 0;
        end else if (!m_latch[m_cur] || m_dwell == ROT - 1) begin
            cur_new = next_after(m_latch, m_cur); dwell_new = 0;
        end else begin
            dwell_new = m_dwell + 1;
        end
        age_new = (m_fire && fire_new) ? m_age + 1 : 0;
        // Display reflects the previous cycle's state and scan position.
        idx = 3 - ((m_cyc / SDIV) % 4);
        m_an = 4'hF;
        m_an[idx] = 1'b0;
        if (m_fire) m_seg = (idx == 0) ? dig_g[m_cur] : fire_g[idx];
        else        m_seg = safe_g[idx];
`ifdef ALARM_BLINK_EN
        if (m_fire && ((m_age / BLINK) % 2 == 1)) m_an = 4'hF;
`endif
        hist.push_front(bus.sensor_in);
        void'(hist.pop_back());
        m_alarm   = (m_latch != 0);
        m_deb_old = m_deb;
        m_deb     = deb_new;
        m_latch   = latch_new;
        m_fire    = fire_new;
        m_cur     = cur_new;
        m_dwell   = dwell_new;
        m_age     = age_new;
        m_cyc++;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("seg", bus.seg, m_seg);
        check("an", bus.an, m_an);
        check("alarm", bus.alarm, m_alarm);
        check("alarm_ch", bus.alarm_ch, m_cur);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus and literal checks ----------------
    initial begin
        int  n;
        bit  found;
        bus.sensor_in = '0;
        bus.ack       = 1'b0;
        rst           = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_an", bus.an, 4'hF);
        check("rst_alarm", bus.alarm, 0);
        check("rst_alarm_ch", bus.alarm_ch, 0);
        rst = 1'b0;

        // First cycles after release: S on digit 3, held SCAN_DIV cycles, then A.
        @(posedge clk); #1;
        check("first_an", bus.an, 4'b0111);
        check("first_seg", bus.seg, 7'h12);
        @(posedge clk); #1;
        check("second_an", bus.an, 4'b0111);
        @(posedge clk); #1;
        check("third_an", bus.an, 4'b1011);
        check("third_seg", bus.seg, 7'h08);
        repeat (20) @(negedge clk);

        // Three-cycle glitch on ch2 must be ignored.
        bus.sensor_in[2] = 1'b1;
        repeat (3) @(negedge clk);
        bus.sensor_in[2] = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_alarm", bus.alarm, 0);

        // Held high on ch2: alarm after exactly DEB+4 edges.
        bus.sensor_in[2] = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.alarm && n < 40);
        check("latency", n, DEB + 4);
        check("fire_ch2", bus.alarm_ch, 2);
        found = 0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(posedge clk); #1;
            if (bus.an == 4'b1110) found = 1;
        end
        check("digit0_seen", found, 1);
        check("digit0_seg", bus.seg, 7'h24);

        // Add ch0: rotation wraps 2 -> 0, each channel shown ROT cycles.
        @(negedge clk);
        bus.sensor_in[0] = 1'b1;
        found = 0;
        for (int k = 0; k < 80 && !found; k++) begin
            @(posedge clk); #1;
            if (bus.alarm_ch == 0) found = 1;
        end
        check("rot_to_0", found, 1);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.alarm_ch == 0 && n < 40);
        check("rot_dwell", n, ROT);
        check("rot_back_2", bus.alarm_ch, 2);

        // Drop ch2, let it debounce low, then ack clears only ch2.
        @(negedge clk);
        bus.sensor_in[2] = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        @(negedge clk);
        check("ack2_ch", bus.alarm_ch, 0);
        check("ack2_alarm", bus.alarm, 1);

        // ack while ch0 is still high has no effect.
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        check("ack0_held_alarm", bus.alarm, 1);
        check("ack0_held_ch", bus.alarm_ch, 0);

        // Drop ch0, debounce, ack: alarm falls one cycle after the latch clears.
        bus.sensor_in[0] = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
        check("safe_alarm_lag", bus.alarm, 1);
        @(negedge clk);
        check("safe_alarm", bus.alarm, 0);
        check("safe_ch", bus.alarm_ch, 0);
        repeat (10) @(negedge clk);

        // Random sensor toggling and acks, with periodic quiet windows.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((i % 500) >= 450) begin
                bus.sensor_in = '0;
            end else begin
                for (int c = 0; c < NUM_CH; c++)
                    if ($urandom_range(0, 7) == 0) bus.sensor_in[c] = ~bus.sensor_in[c];
            end
            bus.ack = ($urandom_range(0, 11) == 0);
        end
        @(negedge clk);
        bus.ack = 1'b0;

        // Reset in the middle of FIRE blanks the display and drops all latches.
        bus.sensor_in = 4'b0010;
        repeat (20) @(negedge clk);
        check("prereset_alarm", bus.alarm, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        bus.sensor_in = '0;
        #1;
        check("midrst_seg", bus.seg, 7'h7F);
        check("midrst_an", bus.an, 4'hF);
        check("midrst_alarm", bus.alarm, 0);
        check("midrst_ch", bus.alarm_ch, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("postrst_alarm", bus.alarm, 0);
        check("postrst_ch", bus.alarm_ch, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
